// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack.
//   STACK_DATA_W / STACK_DEPTH : default word width and entry count.
//   stack_op_e                 : the single operation chosen each cycle by the
//                                strobe priority decode in stack_unit.
package stack_pkg;

  localparam int STACK_DATA_W = 8;
  localparam int STACK_DEPTH  = 16;

  typedef enum logic [2:0] {
    NOP,
    PUSH,
    POP,
    TOS,
    REPLACE
  } stack_op_e;

endpackage

// File: rtl/stack_unit_if.sv
// Strobe/data bundle between the controller (master) and the operand stack (slave).
//   push, pop, tos : operation strobes from the controller
//   din            : word to push
//   clr_err        : clears the sticky error flags
//   dout           : registered read data
//   empty, full    : occupancy flags
//   count          : current occupancy
//   ovf, unf       : sticky overflow / underflow flags
interface stack_unit_if
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
);

  logic              push;
  logic              pop;
  logic              tos;
  logic              clr_err;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              unf;

  modport master (
    output push, pop, tos, clr_err, din,
    input  dout, empty, full, count, ovf, unf
  );

  modport slave (
    input  push, pop, tos, clr_err, din,
    output dout, empty, full, count, ovf, unf
  );

endinterface

// File: rtl/stack_mem.sv
// Storage array for the operand stack.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index (always the current top entry)
//   rdata : combinational read data
// Contents are intentionally not reset.
module stack_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack-machine datapath.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low
//   bus : stack_unit_if.slave (push/pop/tos/din/clr_err in;
//         dout/empty/full/count/ovf/unf out)
// Optional feature: define STACK_ERR_EN to get sticky ovf/unf flags with
// clr_err; without it ovf/unf are constant 0 and clr_err is ignored.
// Illegal operations are suppressed in both builds.
module stack_unit
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic         clk,
  input logic         rst,
  stack_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]  sp_reg;
  logic [CNT_W-1:0]  sp_next;
  logic [DATA_W-1:0] dout_reg;
  logic [DATA_W-1:0] dout_next;
  logic              empty;
  logic              full;
  stack_op_e         op;
  logic              ovf_evt;
  logic              unf_evt;

  logic [AW-1:0]     sp_lo;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     waddr;
  logic              we;
  logic [DATA_W-1:0] top_data;

  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == CNT_W'(DEPTH));

  // With DEPTH a power of two, the low bits of sp minus one give the top
  // index even when sp==DEPTH (low bits 0 wrap to DEPTH-1).
  assign sp_lo   = sp_reg[AW-1:0];
  assign top_idx = sp_lo - AW'(1);

  // Priority decode of the strobes into one operation plus error events.
  always_comb begin
    op      = NOP;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (bus.push && bus.pop) begin
      if (empty) begin
        op      = PUSH;       // pop is dropped; an empty stack is never full
        unf_evt = 1'b1;
      end else begin
        op = REPLACE;
      end
    end else if (bus.push) begin
      if (full) begin
        ovf_evt = 1'b1;
      end else begin
        op = PUSH;
      end
    end else if (bus.pop) begin
      if (empty) begin
        unf_evt = 1'b1;
      end else begin
        op = POP;
      end
    end else if (bus.tos) begin
      // tos is the controller's idle default, so tos on empty is silent.
      if (!empty) begin
        op = TOS;
      end
    end
  end

  always_comb begin
    sp_next   = sp_reg;
    dout_next = dout_reg;
    case (op)
      PUSH: begin
        sp_next = sp_reg + CNT_W'(1);
        if (bus.tos) begin
          dout_next = bus.din;  // bypass the word being pushed
        end
      end
      POP: begin
        sp_next   = sp_reg - CNT_W'(1);
        dout_next = top_data;
      end
      TOS, REPLACE: begin
        dout_next = top_data;
      end
      default: ;
    endcase
  end

  // Gating with rst drops a write that is pending when reset arrives.
  assign we    = rst && ((op == PUSH) || (op == REPLACE));
  assign waddr = (op == REPLACE) ? top_idx : sp_lo;

  stack_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.din),
    .raddr(top_idx),
    .rdata(top_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_reg   <= '0;
      dout_reg <= '0;
    end else begin
      sp_reg   <= sp_next;
      dout_reg <= dout_next;
    end
  end

`ifdef STACK_ERR_EN
  logic ovf_reg;
  logic unf_reg;

  // An error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf_reg <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_reg <= 1'b0;
      end
      if (unf_evt) begin
        unf_reg <= 1'b1;
      end else if (bus.clr_err) begin
        unf_reg <= 1'b0;
      end
    end
  end

  assign bus.ovf = ovf_reg;
  assign bus.unf = unf_reg;
`else
  logic unused_err;
  assign unused_err = ^{bus.clr_err, ovf_evt, unf_evt};

  assign bus.ovf = 1'b0;
  assign bus.unf = 1'b0;
`endif

  assign bus.dout  = dout_reg;
  assign bus.count = sp_reg;
  assign bus.empty = empty;
  assign bus.full  = full;

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;
  import stack_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef STACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; returns 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic t,
                      input logic [DATA_W-1:0] d, input logic c);
    bus.push    = p;
    bus.pop     = q;
    bus.tos     = t;
    bus.din     = d;
    bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.tos     = 1'b0;
    bus.clr_err = 1'b0;
    $display("step push=%0b pop=%0b tos=%0b din=0x%0h clr=%0b -> dout=0x%0h count=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
             p, q, t, d, c, bus.dout, bus.count, bus.empty, bus.full, bus.ovf, bus.unf);
  endtask

  task automatic push_v(input logic [DATA_W-1:0] d);
    step(1'b1, 1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic pop_v();
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.tos     = 1'b0;
    bus.din     = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout",  32'(bus.dout),  32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_unf",   32'(bus.unf),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // LIFO order
    push_v(8'h11);
    push_v(8'h22);
    push_v(8'h33);
    check("lifo_count3", 32'(bus.count), 32'd3);
    pop_v(); check("lifo_pop1", 32'(bus.dout), 32'h33);
    pop_v(); check("lifo_pop2", 32'(bus.dout), 32'h22);
    pop_v(); check("lifo_pop3", 32'(bus.dout), 32'h11);
    check("lifo_count0", 32'(bus.count), 32'd0);
    check("lifo_empty",  32'(bus.empty), 32'd1);

    // tos held
    push_v(8'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, '0, 1'b0);
      check("tos_dout",  32'(bus.dout),  32'hA5);
      check("tos_count", 32'(bus.count), 32'd1);
    end
    pop_v();
    check("tos_pop_count", 32'(bus.count), 32'd0);

    // replace
    push_v(8'h05);
    step(1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
    check("rep_dout",  32'(bus.dout),  32'h05);
    check("rep_count", 32'(bus.count), 32'd1);
    pop_v();
    check("rep_pop_dout", 32'(bus.dout),  32'h09);
    check("rep_empty",    32'(bus.empty), 32'd1);

    // fill and overflow
    for (int i = 0; i < DEPTH; i++) begin
      push_v(8'(i));
    end
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    push_v(8'hFF);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag",  32'(bus.ovf),   32'(ERR));
    pop_v();
    check("ovf_pop_dout",  32'(bus.dout),  32'h0F);
    check("ovf_pop_count", 32'(bus.count), 32'd15);
    check("ovf_pop_full",  32'(bus.full),  32'd0);
    for (int i = 14; i >= 0; i--) begin
      pop_v();
    end
    check("drain_dout",  32'(bus.dout),  32'h00);
    check("drain_empty", 32'(bus.empty), 32'd1);

    // push with tos bypass
    step(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
    check("byp_dout",  32'(bus.dout),  32'h77);
    check("byp_count", 32'(bus.count), 32'd1);
    pop_v();
    check("byp_pop_dout", 32'(bus.dout),  32'h77);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("clr_ovf", 32'(bus.ovf), 32'd0);

    // underflow on empty
    pop_v();
    check("unf_dout",  32'(bus.dout),  32'h77);
    check("unf_flag",  32'(bus.unf),   32'(ERR));
    check("unf_count", 32'(bus.count), 32'd0);
    step(1'b0, 1'b0, 1'b1, '0, 1'b0);
    check("unf_tos_dout", 32'(bus.dout), 32'h77);
    check("unf_tos_flag", 32'(bus.unf),  32'(ERR));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("unf_clr", 32'(bus.unf), 32'd0);

    // push&pop on empty acts as push and flags underflow; set beats clear
    step(1'b1, 1'b1, 1'b0, 8'h66, 1'b1);
    check("pp_empty_count", 32'(bus.count), 32'd1);
    check("pp_empty_unf",   32'(bus.unf),   32'(ERR));
    check("pp_empty_dout",  32'(bus.dout),  32'h77);
    pop_v();
    check("pp_empty_pop", 32'(bus.dout), 32'h66);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("pp_clr", 32'(bus.unf), 32'd0);

    // asynchronous reset between edges, with a push pending
    push_v(8'h44);
    push_v(8'h55);
    check("ar_pre_count", 32'(bus.count), 32'd2);
    #2;
    bus.push = 1'b1;
    bus.din  = 8'h99;
    rst      = 1'b0;
    #1;
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_dout",  32'(bus.dout),  32'd0);
    check("ar_empty", 32'(bus.empty), 32'd1);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    check("ar_hold_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, '0, 1'b0);
    check("ar_tos_dout",  32'(bus.dout),  32'd0);
    check("ar_tos_count", 32'(bus.count), 32'd0);
    check("ar_tos_unf",   32'(bus.unf),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Operand stack for the multicycle stack-machine datapath; consumes the controller's push/pop/tos strobes.
- Holds DEPTH words of DATA_W bits. Returns the popped or top-of-stack word in a registered output that feeds the A/B operand registers.
- Flags stack-empty and stack-full conditions, and optionally records overflow and underflow errors.

Parameters:
- DATA_W, 8, width of a stack word.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- push  in  1  write din onto the stack.
- pop  in  1  remove the top entry and latch it into dout.
- tos  in  1  copy the top entry into dout without removing it.
- din  in  DATA_W  data to push (memory/ALU result mux).
- dout  out  DATA_W  registered read data.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CNT_W  current occupancy.
- clr_err  in  1  clears the sticky error flags (STACK_ERR_EN only).
- ovf  out  1  sticky overflow flag (STACK_ERR_EN only; tied 0 otherwise).
- unf  out  1  sticky underflow flag (STACK_ERR_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst=0, asynchronous): count=0, dout=0, empty=1, full=0, ovf=0, unf=0. Memory contents are not reset.
- State is sp=count. Top entry is mem[sp-1]. All updates happen on the rising clk edge; dout is valid the cycle after the strobe.
- Operation decode, in priority order:
  - push&pop, not empty: replace. mem[sp-1]<=din, dout<=old mem[sp-1], sp unchanged.
  - push&pop, empty: treated as a plain push; pop is dropped and unf is set.
  - push alone, not full: mem[sp]<=din, sp<=sp+1. If tos is also high, dout<=din (bypass).
  - push alone, full: write suppressed, sp unchanged, ovf set.
  - pop alone, not empty: dout<=mem[sp-1], sp<=sp-1. A concurrent tos is ignored.
  - pop alone, empty: sp unchanged, dout unchanged, unf set.
  - tos alone, not empty: dout<=mem[sp-1].
  - tos alone, empty: dout unchanged. No error is raised, because the controller asserts tos as its idle default.
  - No strobe: all state holds.
- empty and full are decoded combinationally from the registered count.
- sp never wraps: it saturates at 0 and at DEPTH.
- Memory write port: a single write per cycle at index sp (push) or sp-1 (replace).
- Reset asserted mid-operation aborts any pending write. The stack is logically emptied immediately, without waiting for a clock edge.

Optional Feature:
- Macro: STACK_ERR_EN.
- Defined:
  - ovf/unf are sticky registers, set by the illegal cases above.
  - clr_err=1 clears both on the next edge. If an error event and clr_err occur in the same cycle, the set wins.
- Undefined:
  - ovf/unf are driven constant 0 and clr_err is ignored.
  - Illegal operations are still suppressed exactly as above.

Decomposition:
- stack_pkg holds:
  - default DATA_W and DEPTH constants;
  - a stack_op_e enum (NOP, PUSH, POP, TOS, REPLACE) produced by the priority decode.
- Sub-module stack_mem: DEPTH×DATA_W register array with one synchronous write port and one combinational read port addressed by sp-1.
- stack_unit contains the decode, the sp counter, the dout register and the flags.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33; pop three times → dout = 0x33, 0x22, 0x11 on the successive cycles after each pop; count ends at 0; empty=1.
- Push 0xA5; tos held for 3 cycles → dout=0xA5 each cycle; count stays 1.
- Push 0x05; push&pop with din=0x09 → dout=0x05, count=1; a following pop → dout=0x09, empty=1.
- Push DEPTH (16) values 0..15, giving full=1; push 0xFF → count stays 16, ovf=1 (when STACK_ERR_EN); pop → dout=0x0F.
- On an empty stack, pop → dout unchanged, unf=1; tos → no new error; clr_err pulse → unf=0.
- Push 0x44, 0x55; assert rst low between clock edges → count=0, dout=0, empty=1 immediately. After release, tos → dout stays 0.
